pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter controller for the 8-bit MIPS-style core.
- Owns the PC register and sequences each instruction: fetch handshake with instruction memory, then a decode/resolve cycle.
- The next PC is chosen from sequential (PC+4), branch target or jump target, using the same jump-target formation as the core's jump unit.
- Provides halt, stall and fetch-timeout handling, and reports status to the top level.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- TIMEOUT, 15, maximum number of FETCH cycles without imem_ack before entering ERROR (1..255).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; leaves IDLE or HALT.
- imem_ack  input  1  instruction memory has the instruction for imem_addr.
- stall  input  1  hold in DECODE; no PC update.
- is_jump  input  1  decoded instruction is an unconditional jump.
- is_branch  input  1  decoded instruction is a conditional branch.
- branch_taken  input  1  branch condition is true.
- is_halt  input  1  decoded instruction is halt.
- br_imm  input  8  signed branch offset, in words.
- jump_field  input  6  jump target field, in words.
- imem_req  output  1  fetch request.
- imem_addr  output  8  fetch address; always equals pc.
- pc  output  8  current PC.
- pc_plus4  output  8  pc + 4, modulo 256 (combinational).
- retire  output  1  one-cycle pulse when the PC advances.
- redirect  output  1  one-cycle pulse when the PC advances to a non-sequential target.
- halted  output  1  high in HALT.
- err  output  1  high in ERROR.

Behaviour:
- Reset (asynchronous; takes effect immediately, including mid-fetch):
  - state = IDLE, pc = RESET_PC, timeout counter = 0.
  - imem_req, retire, redirect, halted and err all 0.
- Arithmetic, all 8-bit, wrapping modulo 256, no overflow flag:
  - pc_plus4 = pc + 4.
  - Branch target = pc_plus4 + {br_imm[5:0], 2'b00}, with br_imm read as signed; upper bits are discarded by the wrap.
  - Jump target = {jump_field, 2'b00}.
- States: IDLE, FETCH, DECODE, HALT, ERROR.
- IDLE:
  - imem_req = 0.
  - start -> FETCH; the timeout counter clears.
- FETCH:
  - imem_req = 1 combinationally; imem_addr = pc.
  - On imem_ack -> DECODE; the counter clears.
  - Otherwise the counter increments. When the counter == TIMEOUT and there is still no ack -> ERROR.
  - An ack in the same cycle the counter reaches TIMEOUT takes priority and goes to DECODE.
- DECODE:
  - imem_req = 0.
  - If stall = 1: stay in DECODE, pc unchanged, retire = 0. Stall is ignored in every other state.
  - Otherwise the PC updates at the end of the cycle, with this priority:
    - is_halt: pc <= pc_plus4, go to HALT.
    - else is_jump: pc <= jump target, redirect.
    - else is_branch & branch_taken: pc <= branch target, redirect.
    - else: pc <= pc_plus4.
  - Non-halt cases return to FETCH.
  - retire and redirect are registered and pulse in the cycle after the update; redirect = 0 for halt and sequential updates.
  - Decode inputs are sampled only in non-stalled DECODE cycles.
- HALT:
  - halted = 1; pc holds the halt address + 4.
  - start -> FETCH from the current pc.
- ERROR:
  - err = 1; pc holds the faulting address.
  - Exits only on reset; start is ignored.
- start in FETCH or DECODE is ignored.
- imem_ack outside FETCH is ignored.
- Throughput: at best one instruction per 2 cycles (FETCH with immediate ack, then DECODE).

Test Plan:
- Reset with RESET_PC = 0, pulse start, ack each fetch immediately, no branches/jumps -> imem_addr sequence 0x00, 0x04, 0x08, 0x0C; retire pulses once per 2 cycles; redirect = 0 throughout.
- Branch: pc = 0x10, is_branch = 1, branch_taken = 1, br_imm = 8'hFE -> next pc = 0x0C, redirect pulses. Repeat with branch_taken = 0 -> pc = 0x14, redirect = 0.
- Jump priority: pc = 0x20, is_jump = 1 and is_branch = branch_taken = 1, jump_field = 6'h05 -> pc = 0x14 (jump wins), redirect pulses.
- Wrap-around: pc = 0xFC sequential -> pc = 0x00; pc = 0xF8, branch br_imm = 8'h02 -> target 0xFC + 0x08 = 0x04.
- Stall then halt: hold stall = 1 for 3 DECODE cycles at pc = 0x30 -> pc stays 0x30, no retire. Release stall with is_halt = 1 -> pc = 0x34, halted = 1. start -> fetch at 0x34.
- Timeout and reset:
  - TIMEOUT = 15, hold imem_ack = 0 in FETCH -> ERROR after the 16th FETCH cycle; err = 1; start has no effect.
  - Assert reset mid-FETCH on a fresh run -> imem_req drops in the same cycle, without waiting for clk; pc = RESET_PC; err = 0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bundles the instruction-fetch handshake, decode controls and status
// signals of the program-counter sequencer.
interface pc_sequencer_if;
  logic       start;
  logic       imem_ack;
  logic       stall;
  logic       is_jump;
  logic       is_branch;
  logic       branch_taken;
  logic       is_halt;
  logic [7:0] br_imm;
  logic [5:0] jump_field;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] pc;
  logic [7:0] pc_plus4;
  logic       retire;
  logic       redirect;
  logic       halted;
  logic       err;

  // Sequencer side: drives fetch requests, PC and status.
  modport master (
    input  start, imem_ack, stall, is_jump, is_branch, branch_taken,
           is_halt, br_imm, jump_field,
    output imem_req, imem_addr, pc, pc_plus4, retire, redirect, halted, err
  );

  // Environment side: instruction memory, decoder and top-level control.
  modport slave (
    output start, imem_ack, stall, is_jump, is_branch, branch_taken,
           is_halt, br_imm, jump_field,
    input  imem_req, imem_addr, pc, pc_plus4, retire, redirect, halted, err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter controller for the 8-bit MIPS-style core: owns the PC,
// runs the fetch handshake and a decode/resolve cycle per instruction,
// and handles halt, stall and fetch timeout.
module pc_sequencer #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned TIMEOUT  = 15
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, HALT, ERROR} state_t;

  localparam logic [7:0] TMO = TIMEOUT[7:0];

  state_t     state, state_n;
  logic [7:0] pc_q, pc_n;
  logic [7:0] cnt, cnt_n;
  logic       retire_q, retire_n;
  logic       redirect_q, redirect_n;
  logic [7:0] seq_pc;
  logic [7:0] br_target;
  logic [7:0] jmp_target;
  logic       unused_br_hi;

  // Target arithmetic; the branch offset keeps only the bits that survive the 8-bit wrap.
  always_comb begin
    seq_pc       = pc_q + 8'd4;
    br_target    = seq_pc + {bus.br_imm[5:0], 2'b00};
    jmp_target   = {bus.jump_field, 2'b00};
    unused_br_hi = ^bus.br_imm[7:6];
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // PC, timeout counter and registered retire/redirect pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      cnt        <= '0;
      retire_q   <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_n;
      cnt        <= cnt_n;
      retire_q   <= retire_n;
      redirect_q <= redirect_n;
    end
  end

  // Next-state, next-PC and timeout counter selection.
  always_comb begin
    state_n    = state;
    pc_n       = pc_q;
    cnt_n      = cnt;
    retire_n   = 1'b0;
    redirect_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = FETCH;
          cnt_n   = '0;
        end
      end
      FETCH: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (bus.imem_ack) begin
          state_n = DECODE;
          cnt_n   = '0;
        end else if (cnt == TMO) begin
          state_n = ERROR;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DECODE: begin
        if (!bus.stall) begin
          retire_n = 1'b1;
          if (bus.is_halt) begin
            pc_n    = seq_pc;
            state_n = HALT;
          end else if (bus.is_jump) begin
            pc_n       = jmp_target;
            redirect_n = 1'b1;
            state_n    = FETCH;
          end else if (bus.is_branch && bus.branch_taken) begin
            pc_n       = br_target;
            redirect_n = 1'b1;
            state_n    = FETCH;
          end else begin
            pc_n    = seq_pc;
            state_n = FETCH;
          end
        end
      end
      HALT: begin
        if (bus.start) begin
          state_n = FETCH;
          cnt_n   = '0;
        end
      end
      ERROR: state_n = ERROR;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from state and registers.
  always_comb begin
    bus.imem_req  = (state == FETCH);
    bus.imem_addr = pc_q;
    bus.pc        = pc_q;
    bus.pc_plus4  = seq_pc;
    bus.retire    = retire_q;
    bus.redirect  = redirect_q;
    bus.halted    = (state == HALT);
    bus.err       = (state == ERROR);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(8'h00), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_decode();
    bus.stall        = 1'b0;
    bus.is_jump      = 1'b0;
    bus.is_branch    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.is_halt      = 1'b0;
    bus.br_imm       = 8'h00;
    bus.jump_field   = 6'h00;
  endtask

  // Starts in FETCH: immediate ack, one DECODE cycle, then check the update.
  task automatic do_instr(input string tag, input logic [7:0] exp_addr,
                          input logic jmp, input logic br, input logic tk,
                          input logic [7:0] imm, input logic [5:0] jf,
                          input logic [7:0] exp_pc, input logic exp_redir);
    chk({tag, "_req"}, {7'd0, bus.imem_req}, 8'd1);
    chk({tag, "_addr"}, bus.imem_addr, exp_addr);
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk({tag, "_dec_req"}, {7'd0, bus.imem_req}, 8'd0);
    chk({tag, "_dec_retire"}, {7'd0, bus.retire}, 8'd0);
    bus.is_jump      = jmp;
    bus.is_branch    = br;
    bus.branch_taken = tk;
    bus.br_imm       = imm;
    bus.jump_field   = jf;
    tick();
    clear_decode();
    chk({tag, "_pc"}, bus.pc, exp_pc);
    chk({tag, "_retire"}, {7'd0, bus.retire}, 8'd1);
    chk({tag, "_redirect"}, {7'd0, bus.redirect}, {7'd0, exp_redir});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.start    = 1'b0;
    bus.imem_ack = 1'b0;
    clear_decode();
    #1;
    chk("rst_req", {7'd0, bus.imem_req}, 8'd0);
    chk("rst_pc", bus.pc, 8'h00);
    chk("rst_retire", {7'd0, bus.retire}, 8'd0);
    chk("rst_redirect", {7'd0, bus.redirect}, 8'd0);
    chk("rst_halted", {7'd0, bus.halted}, 8'd0);
    chk("rst_err", {7'd0, bus.err}, 8'd0);
    chk("rst_plus4", bus.pc_plus4, 8'h04);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_req", {7'd0, bus.imem_req}, 8'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;

    // Sequential run
    do_instr("seq0", 8'h00, 0, 0, 0, 8'h00, 6'h00, 8'h04, 0);
    do_instr("seq1", 8'h04, 0, 0, 0, 8'h00, 6'h00, 8'h08, 0);
    do_instr("seq2", 8'h08, 0, 0, 0, 8'h00, 6'h00, 8'h0C, 0);
    do_instr("seq3", 8'h0C, 0, 0, 0, 8'h00, 6'h00, 8'h10, 0);
    // Branches
    do_instr("brt", 8'h10, 0, 1, 1, 8'hFE, 6'h00, 8'h0C, 1);
    do_instr("jmp10", 8'h0C, 1, 0, 0, 8'h00, 6'h04, 8'h10, 1);
    do_instr("brnt", 8'h10, 0, 1, 0, 8'hFE, 6'h00, 8'h14, 0);
    do_instr("jmp20", 8'h14, 1, 0, 0, 8'h00, 6'h08, 8'h20, 1);
    do_instr("jprio", 8'h20, 1, 1, 1, 8'hFE, 6'h05, 8'h14, 1);
    // Wrap-around
    do_instr("jmpFC", 8'h14, 1, 0, 0, 8'h00, 6'h3F, 8'hFC, 1);
    do_instr("wrapseq", 8'hFC, 0, 0, 0, 8'h00, 6'h00, 8'h00, 0);
    do_instr("jmpF8", 8'h00, 1, 0, 0, 8'h00, 6'h3E, 8'hF8, 1);
    do_instr("wrapbr", 8'hF8, 0, 1, 1, 8'h02, 6'h00, 8'h04, 1);
    do_instr("jmp30", 8'h04, 1, 0, 0, 8'h00, 6'h0C, 8'h30, 1);

    // Stall then halt at 0x30
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b1;
    bus.is_jump  = 1'b1;
    bus.jump_field = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bus.pc, 8'h30);
      chk("stall_retire", {7'd0, bus.retire}, 8'd0);
      chk("stall_req", {7'd0, bus.imem_req}, 8'd0);
    end
    clear_decode();
    bus.is_halt = 1'b1;
    tick();
    clear_decode();
    chk("halt_pc", bus.pc, 8'h34);
    chk("halt_halted", {7'd0, bus.halted}, 8'd1);
    chk("halt_retire", {7'd0, bus.retire}, 8'd1);
    chk("halt_redirect", {7'd0, bus.redirect}, 8'd0);
    tick();
    chk("halt_hold", {7'd0, bus.halted}, 8'd1);
    chk("halt_retire2", {7'd0, bus.retire}, 8'd0);
    chk("halt_req", {7'd0, bus.imem_req}, 8'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("resume_halted", {7'd0, bus.halted}, 8'd0);
    do_instr("resume", 8'h34, 0, 0, 0, 8'h00, 6'h00, 8'h38, 0);

    // Ack arriving on the 16th FETCH cycle still wins
    for (int i = 0; i < 15; i++) tick();
    chk("late_req", {7'd0, bus.imem_req}, 8'd1);
    chk("late_err", {7'd0, bus.err}, 8'd0);
    do_instr("lateack", 8'h38, 0, 0, 0, 8'h00, 6'h00, 8'h3C, 0);

    // Timeout to ERROR
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_pre_err", {7'd0, bus.err}, 8'd0);
    chk("tmo_pre_req", {7'd0, bus.imem_req}, 8'd1);
    tick();
    chk("tmo_err", {7'd0, bus.err}, 8'd1);
    chk("tmo_req", {7'd0, bus.imem_req}, 8'd0);
    chk("tmo_pc", bus.pc, 8'h3C);
    bus.start    = 1'b1;
    bus.imem_ack = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.imem_ack = 1'b0;
    tick();
    chk("err_sticky", {7'd0, bus.err}, 8'd1);
    chk("err_req", {7'd0, bus.imem_req}, 8'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("err_rst_err", {7'd0, bus.err}, 8'd0);
    chk("err_rst_pc", bus.pc, 8'h00);
    tick();
    reset = 1'b0;

    // Asynchronous reset in the middle of a fetch
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("mid_req_before", {7'd0, bus.imem_req}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_req_after", {7'd0, bus.imem_req}, 8'd0);
    chk("mid_pc", bus.pc, 8'h00);
    chk("mid_err", {7'd0, bus.err}, 8'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_idle", {7'd0, bus.imem_req}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
